switch_driver: RTL and testbench



---
 rtl/voltmeter_pkg.sv | 21 ++
 rtl/switch_driver_if.sv | 29 ++
 rtl/sw_drv_timer.sv | 32 +++
 rtl/switch_driver.sv | 180 ++++++++++++++++++
 tb/tb_switch_driver.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/voltmeter_pkg.sv
// Shared constants for the switch driver.
// Holds the FSM state encoding and the named integrator input select codes.
// No ports.
package voltmeter_pkg;

    typedef logic [1:0] state_t;

    // State encoding. The states are kept as plain constants so that older
    // tools and netlists can still read the encoding.
    localparam state_t ST_OFF   = 2'd0;
    localparam state_t ST_BREAK = 2'd1;
    localparam state_t ST_ON    = 2'd2;

    // Integrator input select codes. SEL_OFF, or any code of NUM_SW or
    // above, opens every switch.
    localparam logic [1:0] SEL_ZERO = 2'd0;
    localparam logic [1:0] SEL_VIN  = 2'd1;
    localparam logic [1:0] SEL_VREF = 2'd2;
    localparam logic [1:0] SEL_OFF  = 2'd3;

endpackage

// File: rtl/switch_driver_if.sv
// Request channel from the digital controller to the switch driver.
// Signals:
//   req_valid_i  controller -> driver  request valid
//   req_sel_i    controller -> driver  requested select code
//   req_ready_o  driver -> controller  request can be taken this cycle
//   abort_i      controller -> driver  open all switches, overrides requests
// Modports: master (controller side), slave (driver side).
interface switch_driver_if #(
    parameter int SEL_W = 2
);
    logic             req_valid_i;
    logic [SEL_W-1:0] req_sel_i;
    logic             req_ready_o;
    logic             abort_i;

    modport master (
        output req_valid_i,
        output req_sel_i,
        output abort_i,
        input  req_ready_o
    );

    modport slave (
        input  req_valid_i,
        input  req_sel_i,
        input  abort_i,
        output req_ready_o
    );
endinterface

// File: rtl/sw_drv_timer.sv
// Loadable down-counter that saturates at zero.
// One instance is shared by the dead-time and dwell phases, because only one
// of those phases can be active at a time.
// Ports:
//   clk       clock
//   rst       synchronous active-high reset, clears the count
//   load      load load_val this cycle; takes priority over counting
//   load_val  value to load
//   zero      high while the count is zero
module sw_drv_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);
    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

    assign zero = (count == '0);
endmodule

// File: rtl/switch_driver.sv
// Break-before-make driver for the integrator input select switches.
// Enforces a dead time with every switch open between any two closed
// switches, and a minimum dwell before a closed switch can be changed.
// Optional macro SWITCH_DRIVER_READBACK_EN adds the sw_fb_i readback check
// and the sticky fault_o flag; without it fault_o is tied low.
// Ports:
//   clk_i, rst_i   clock; synchronous active-high reset
//   req            request channel (switch_driver_if.slave)
//   sw_fb_i        switch feedback (only with SWITCH_DRIVER_READBACK_EN)
//   sw_en_o        registered switch enables, one-hot or zero
//   active_sel_o   select code currently targeted
//   busy_o         high during dead time
//   fault_o        sticky readback fault
//
// state    | meaning
// ST_OFF   | all switches open, ready for a request
// ST_BREAK | dead time, all open, timer counting toward the next target
// ST_ON    | one switch closed, ready again once the dwell timer is zero
module switch_driver
    import voltmeter_pkg::*;
#(
    parameter int NUM_SW      = 3,
    parameter int SEL_W       = 2,
    parameter int DEAD_CYCLES = 4,
    parameter int MIN_DWELL   = 8,
    parameter int CNT_W       = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    switch_driver_if.slave    req,
`ifdef SWITCH_DRIVER_READBACK_EN
    input  logic [NUM_SW-1:0] sw_fb_i,
`endif
    output logic [NUM_SW-1:0] sw_en_o,
    output logic [SEL_W-1:0]  active_sel_o,
    output logic              busy_o,
    output logic              fault_o
);
    localparam logic [SEL_W-1:0] NUM_SW_SEL = SEL_W'(NUM_SW);
    localparam logic [CNT_W-1:0] DEAD_LOAD  = CNT_W'(DEAD_CYCLES - 1);
    localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(MIN_DWELL - 1);

    state_t           state;
    logic             timer_zero;
    logic             timer_load;
    logic [CNT_W-1:0] timer_val;
    logic             abort_all;
    logic             accept;
    logic             sel_ok;
    logic             active_ok;
    logic             sel_change;

    function automatic logic [NUM_SW-1:0] onehot(input logic [SEL_W-1:0] s);
        onehot = '0;
        for (int i = 0; i < NUM_SW; i++) begin
            if (s == SEL_W'(i)) onehot[i] = 1'b1;
        end
    endfunction

`ifdef SWITCH_DRIVER_READBACK_EN
    logic fault_q;
    logic fb_abort;
    logic fb_check;
    logic fb_mismatch;

    // Feedback is only meaningful once the switches have settled: idle, or
    // closed with the dwell complete.
    assign fb_check    = (state == ST_OFF) || ((state == ST_ON) && timer_zero);
    assign fb_mismatch = fb_check && (sw_fb_i != sw_en_o);

    // The internal abort is a single pulse on the first mismatch; a held
    // abort would keep reloading the dead time and never reach OFF.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fault_q  <= 1'b0;
            fb_abort <= 1'b0;
        end else begin
            fault_q  <= fault_q | fb_mismatch;
            fb_abort <= fb_mismatch & ~fault_q;
        end
    end

    assign abort_all = req.abort_i | fb_abort;
    assign fault_o   = fault_q;
`else
    assign abort_all = req.abort_i;
    assign fault_o   = 1'b0;
`endif

    assign req.req_ready_o = !abort_all && !fault_o &&
                             ((state == ST_OFF) || ((state == ST_ON) && timer_zero));
    assign accept     = req.req_valid_i && req.req_ready_o;
    assign sel_ok     = (req.req_sel_i < NUM_SW_SEL);
    assign active_ok  = (active_sel_o < NUM_SW_SEL);
    assign sel_change = (req.req_sel_i != active_sel_o);
    assign busy_o     = (state == ST_BREAK);

    always_comb begin
        timer_load = 1'b0;
        timer_val  = DEAD_LOAD;
        case (state)
            ST_OFF: begin
                if (accept && sel_ok) begin
                    timer_load = 1'b1;
                    timer_val  = DWELL_LOAD;
                end
            end
            ST_ON: begin
                if (abort_all || (accept && sel_change)) begin
                    timer_load = 1'b1;
                end
            end
            ST_BREAK: begin
                if (abort_all) begin
                    timer_load = 1'b1;
                end else if (timer_zero && active_ok) begin
                    timer_load = 1'b1;
                    timer_val  = DWELL_LOAD;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= ST_OFF;
            sw_en_o      <= '0;
            active_sel_o <= '1;
        end else begin
            case (state)
                ST_OFF: begin
                    if (accept && sel_ok) begin
                        state        <= ST_ON;
                        active_sel_o <= req.req_sel_i;
                        sw_en_o      <= onehot(req.req_sel_i);
                    end
                end
                ST_ON: begin
                    if (abort_all) begin
                        state        <= ST_BREAK;
                        active_sel_o <= '1;
                        sw_en_o      <= '0;
                    end else if (accept && sel_change) begin
                        state        <= ST_BREAK;
                        active_sel_o <= req.req_sel_i;
                        sw_en_o      <= '0;
                    end
                end
                ST_BREAK: begin
                    if (abort_all) begin
                        active_sel_o <= '1;
                    end else if (timer_zero) begin
                        if (active_ok) begin
                            state   <= ST_ON;
                            sw_en_o <= onehot(active_sel_o);
                        end else begin
                            state <= ST_OFF;
                        end
                    end
                end
                default: begin
                    state        <= ST_OFF;
                    sw_en_o      <= '0;
                    active_sel_o <= '1;
                end
            endcase
        end
    end

    sw_drv_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk      (clk_i),
        .rst      (rst_i),
        .load     (timer_load),
        .load_val (timer_val),
        .zero     (timer_zero)
    );
endmodule

// File: tb/tb_switch_driver.sv
module tb_switch_driver;
    localparam int NUM_SW = 3;
    localparam int SEL_W  = 2;
    localparam int DEAD   = 4;
    localparam int DWELL  = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    switch_driver_if #(.SEL_W(SEL_W)) bus ();

    logic [NUM_SW-1:0] sw_en;
    logic [SEL_W-1:0]  active_sel;
    logic              busy;
    logic              fault;

`ifdef SWITCH_DRIVER_READBACK_EN
    logic              fb_force = 1'b0;
    logic [NUM_SW-1:0] fb_val   = '0;
    logic [NUM_SW-1:0] sw_fb;
    assign sw_fb = fb_force ? fb_val : sw_en;
`endif

    switch_driver #(
        .NUM_SW(NUM_SW), .SEL_W(SEL_W), .DEAD_CYCLES(DEAD), .MIN_DWELL(DWELL), .CNT_W(8)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req          (bus),
`ifdef SWITCH_DRIVER_READBACK_EN
        .sw_fb_i      (sw_fb),
`endif
        .sw_en_o      (sw_en),
        .active_sel_o (active_sel),
        .busy_o       (busy),
        .fault_o      (fault)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    endtask

    // Reference model: which switch is closed, which target is pending, and
    // the cycle stamps at which the dead time ends / the switch was closed.
    int m_closed, m_tgt, m_break_end, m_close_cyc, cyc;
    bit m_in_break;
    bit cur_v, cur_a;
    int cur_s;
    logic [NUM_SW-1:0] prev_sw;

    function automatic int m_sw_en();
        return (m_closed < 0) ? 0 : (1 << m_closed);
    endfunction

    function automatic bit m_ready(input bit a);
        if (a || m_in_break) return 1'b0;
        if (m_closed < 0) return 1'b1;
        return cyc >= m_close_cyc + DWELL - 1;
    endfunction

    task automatic m_reset();
        m_closed = -1; m_tgt = 3; m_in_break = 0; m_break_end = 0; m_close_cyc = 0;
        cyc = 0; prev_sw = '0;
    endtask

    task automatic m_step(input bit v, input int s, input bit a);
        bit acc;
        acc = v && m_ready(a);
        if (m_in_break) begin
            if (a) begin
                m_tgt = 3; m_break_end = cyc + 1 + DEAD;
            end else if (cyc + 1 == m_break_end) begin
                m_in_break = 0;
                if (m_tgt < NUM_SW) begin m_closed = m_tgt; m_close_cyc = cyc + 1; end
            end
        end else if (m_closed >= 0) begin
            if (a) begin
                m_in_break = 1; m_break_end = cyc + 1 + DEAD; m_closed = -1; m_tgt = 3;
            end else if (acc && s != m_tgt) begin
                m_in_break = 1; m_break_end = cyc + 1 + DEAD; m_closed = -1; m_tgt = s;
            end
        end else if (acc && s < NUM_SW) begin
            m_closed = s; m_tgt = s; m_close_cyc = cyc + 1;
        end
    endtask

    // Called at posedge+1: drive inputs, then compare at posedge+3.
    task automatic apply(input bit v, input int s, input bit a);
        cur_v = v; cur_s = s; cur_a = a;
        bus.req_valid_i = v;
        bus.req_sel_i   = s[SEL_W-1:0];
        bus.abort_i     = a;
        #2;
        check("model_sw_en", sw_en, m_sw_en());
        check("model_ready", bus.req_ready_o, m_ready(a));
        check("model_busy", busy, m_in_break);
        check("model_active", active_sel, m_tgt);
        check("model_fault", fault, 0);
        check("onehot", ($countones(sw_en) <= 1), 1);
        check("break_before_make", (prev_sw != 0 && sw_en != 0 && sw_en != prev_sw), 0);
        prev_sw = sw_en;
    endtask

    task automatic advance();
        m_step(cur_v, cur_s, cur_a);
        @(posedge clk); #1;
        cyc++;
    endtask

    task automatic do_cycle(input bit v, input int s, input bit a);
        apply(v, s, a);
        advance();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req_valid_i = 1'b0; bus.req_sel_i = '0; bus.abort_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        m_reset();
        #2;
        check("rst_sw_en", sw_en, 0);
        check("rst_active", active_sel, 3);
        check("rst_busy", busy, 0);
        check("rst_fault", fault, 0);
        check("rst_ready", bus.req_ready_o, 1);
        @(posedge clk); #1;
        cyc++;
    endtask

    typedef struct {
        bit v; int s; bit a;
        int e_sw; bit e_rdy; bit e_busy; int e_act;
    } vec_t;
    vec_t vecs[$];

    task automatic add(input bit v, input int s, input bit a,
                       input int e_sw, input bit e_rdy, input bit e_busy, input int e_act);
        vec_t t;
        t.v = v; t.s = s; t.a = a; t.e_sw = e_sw; t.e_rdy = e_rdy; t.e_busy = e_busy; t.e_act = e_act;
        vecs.push_back(t);
    endtask

    initial begin
        bus.req_valid_i = 1'b0; bus.req_sel_i = '0; bus.abort_i = 1'b0;

        // Directed table, starting right after reset.
        add(1, 1, 0, 0, 1, 0, 3);
        repeat (7) add(0, 0, 0, 2, 0, 0, 1);
        add(1, 2, 0, 2, 1, 0, 1);
        repeat (4) add(0, 0, 0, 0, 0, 1, 2);
        add(0, 0, 0, 4, 0, 0, 2);
        repeat (6) add(0, 0, 0, 4, 0, 0, 2);
        add(0, 0, 0, 4, 1, 0, 2);
        add(1, 2, 0, 4, 1, 0, 2);
        add(0, 0, 0, 4, 1, 0, 2);
        add(1, 3, 0, 4, 1, 0, 2);
        repeat (4) add(0, 0, 0, 0, 0, 1, 3);
        add(0, 0, 0, 0, 1, 0, 3);
        add(1, 3, 0, 0, 1, 0, 3);
        add(0, 0, 0, 0, 1, 0, 3);
        add(0, 0, 1, 0, 0, 0, 3);
        add(0, 0, 0, 0, 1, 0, 3);

        do_reset();
        foreach (vecs[i]) begin
            apply(vecs[i].v, vecs[i].s, vecs[i].a);
            check($sformatf("vec%0d_sw_en", i), sw_en, vecs[i].e_sw);
            check($sformatf("vec%0d_ready", i), bus.req_ready_o, vecs[i].e_rdy);
            check($sformatf("vec%0d_busy", i), busy, vecs[i].e_busy);
            check($sformatf("vec%0d_active", i), active_sel, vecs[i].e_act);
            advance();
        end

        // Abort together with a valid request while ON.
        do_cycle(1, 0, 0);
        repeat (7) do_cycle(0, 0, 0);
        apply(1, 2, 1);
        check("abort_ready", bus.req_ready_o, 0);
        advance();
        apply(0, 0, 0);
        check("abort_sw_en", sw_en, 0);
        check("abort_active", active_sel, 3);
        advance();
        repeat (3) do_cycle(0, 0, 0);
        apply(0, 0, 0);
        check("abort_off_ready", bus.req_ready_o, 1);
        check("abort_off_busy", busy, 0);
        advance();

        // Abort during dead time restarts it.
        do_cycle(1, 1, 0);
        repeat (7) do_cycle(0, 0, 0);
        do_cycle(1, 2, 0);
        do_cycle(0, 0, 0);
        do_cycle(0, 0, 1);
        repeat (6) do_cycle(0, 0, 0);

        // Reset in the middle of dead time.
        do_cycle(1, 1, 0);
        repeat (7) do_cycle(0, 0, 0);
        do_cycle(1, 0, 0);
        apply(0, 0, 0);
        check("mid_break_busy", busy, 1);
        do_reset();

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0) do_reset();
            else do_cycle(($urandom_range(0, 2) != 0), int'($urandom_range(0, 3)),
                          ($urandom_range(0, 19) == 0));
        end

`ifdef SWITCH_DRIVER_READBACK_EN
        // Feedback stuck open while switch 1 is closed and dwell complete.
        do_reset();
        fb_force = 1'b1; fb_val = '0;
        do_cycle(1, 1, 0);
        repeat (7) do_cycle(0, 0, 0);
        apply(0, 0, 0);
        @(posedge clk); #1;
        bus.req_valid_i = 1'b1; bus.req_sel_i = 2'd0;
        #2;
        check("rb_fault", fault, 1);
        check("rb_sw_en_held", sw_en, 2);
        check("rb_ready_fault", bus.req_ready_o, 0);
        @(posedge clk); #3;
        check("rb_sw_en_open", sw_en, 0);
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #3;
            check("rb_ready_stuck", bus.req_ready_o, 0);
            check("rb_fault_sticky", fault, 1);
            check("rb_sw_en_stays_open", sw_en, 0);
        end
        fb_force = 1'b0;
        @(posedge clk); #1;
        do_reset();
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
